// File: rtl/dac_player_if.sv
// Parallel-side signals of the DAC playback serializer: codec timing, SRAM read
// data and playback controls in; read enable, serial data and done flag out.
interface dac_player_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 18,
    parameter int SPEED_W = 4
);
    logic               play;
    logic               daclrc;
    logic [SPEED_W-1:0] fast;
    logic [SPEED_W-1:0] slow;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  end_addr;
    logic [DATA_W-1:0]  data;
    logic               read;
    logic               dacdat;
    logic               done;

    modport master (
        output play, daclrc, fast, slow, start_addr, end_addr, data,
        input  read, dacdat, done
    );

    modport slave (
        input  play, daclrc, fast, slow, start_addr, end_addr, data,
        output read, dacdat, done
    );
endinterface

// File: rtl/dac_player.sv
// SRAM-fed I2S playback serializer with fast/slow variable-speed stepping.
// Define DAC_PLAYER_LOOP_EN to wrap to start_addr at end_addr instead of stopping in DONE.
module dac_player #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 18,
    parameter int SPEED_W = 4
) (
    input  logic              bclk,
    input  logic              rst,
    dac_player_if.slave       bus,
    output logic [ADDR_W-1:0] addr
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int NXT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [SPEED_W-1:0] rep_q;
    logic [DATA_W-1:0]  cur_q;
    logic [DATA_W-1:0]  sh_q;
    logic [CNT_W-1:0]   bits_q;
    logic               lrc_q;
    logic               read_q;
    logic               done_q;
    logic               dacdat_q;

    logic [SPEED_W-1:0] fast_eff;
    logic [SPEED_W-1:0] slow_eff;
    logic [NXT_W-1:0]   nxt;
    logic               ch_start;
    logic               left_start;
    logic               fetch;
    logic               at_end;

    always_comb begin
        fast_eff   = (bus.fast == '0) ? SPEED_W'(1) : bus.fast;
        slow_eff   = (bus.slow == '0) ? SPEED_W'(1) : bus.slow;
        nxt        = {1'b0, addr_q} + NXT_W'(fast_eff);
        at_end     = nxt > {1'b0, bus.end_addr};
        ch_start   = bus.daclrc != lrc_q;
        left_start = bus.daclrc && !lrc_q;
        fetch      = left_start && (rep_q == '0);
    end

    always_ff @(posedge bclk) begin
        lrc_q <= bus.daclrc;
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rep_q    <= '0;
            cur_q    <= '0;
            sh_q     <= '0;
            bits_q   <= '0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
            dacdat_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dacdat_q <= 1'b0;
                    bits_q   <= '0;
                    if (bus.play) begin
                        state_q <= PLAY;
                        read_q  <= 1'b1;
                        addr_q  <= bus.start_addr;
                        rep_q   <= '0;
                        cur_q   <= '0;
                    end
                end
                PLAY, DONE: begin
                    if (!bus.play) begin
                        state_q  <= IDLE;
                        read_q   <= 1'b0;
                        done_q   <= 1'b0;
                        dacdat_q <= 1'b0;
                        bits_q   <= '0;
                    end else begin
                        // Channel start emits the I2S dead bit; a fetching left start bypasses cur_q.
                        if (ch_start) begin
                            dacdat_q <= 1'b0;
                            bits_q   <= CNT_FULL;
                            if (state_q == DONE && left_start)
                                sh_q <= '0;
                            else if (state_q == PLAY && fetch)
                                sh_q <= bus.data;
                            else
                                sh_q <= cur_q;
                        end else if (bits_q != '0) begin
                            dacdat_q <= sh_q[DATA_W-1];
                            sh_q     <= {sh_q[DATA_W-2:0], 1'b0};
                            bits_q   <= bits_q - 1'b1;
                        end else begin
                            dacdat_q <= 1'b0;
                        end

                        if (state_q == DONE) begin
                            if (left_start)
                                cur_q <= '0;
                        end else if (left_start) begin
                            rep_q <= (rep_q == slow_eff - 1'b1) ? '0 : rep_q + 1'b1;
                            if (fetch) begin
                                cur_q <= bus.data;
                                if (!at_end) begin
                                    addr_q <= nxt[ADDR_W-1:0];
                                end else begin
`ifdef DAC_PLAYER_LOOP_EN
                                    addr_q <= bus.start_addr;
`else
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr       = (state_q == IDLE) ? 'z : addr_q;
    assign bus.read   = read_q;
    assign bus.dacdat = dacdat_q;
    assign bus.done   = done_q;
endmodule
